rc5_core: RTL
=============

RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 The block SHALL have parameter W, default 8: data word width in bits; power of two, 8..64.
REQ-002 The block SHALL have parameter R, default 6: round count, 1..32; the key table holds T = 2R+2 words.
REQ-003 The block SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port key_we, input, 1: key-table write strobe.
REQ-006 The block SHALL have port key_addr, input, 6: key-table index 0..T-1.
REQ-007 The block SHALL have port key_data, input, W: key-table word.
REQ-008 The block SHALL have port in_valid, input, 1: input block offered.
REQ-009 The block SHALL have port in_ready, output, 1: core can accept a block.
REQ-010 The block SHALL have port in_mode, input, 1: 0 = encrypt, 1 = decrypt.
REQ-011 The block SHALL have ports in_a and in_b, input, W each: input words A and B.
REQ-012 The block SHALL have port out_valid, output, 1: result available.
REQ-013 The block SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 The block SHALL have ports out_a and out_b, output, W each: result words A and B.

Function
REQ-015 The FSM SHALL have states IDLE, PRE, HA, HB, POST and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Key-table write: on key_we in IDLE with key_addr < T, the core SHALL write S[key_addr] = key_data.
- A write with key_addr >= T SHALL be ignored.
- A write outside IDLE SHALL be ignored.
REQ-017 Acceptance occurs on an edge with in_valid & in_ready; the core SHALL then latch A, B and mode, and set round index i.
- Encrypt: i = 1, next state PRE.
- Decrypt: i = R, next state HB.
REQ-018 Encrypt PRE SHALL compute A = A + S[0] and B = B + S[1], then go to HA.
REQ-019 Encrypt HA SHALL compute A = ((A ^ B) <<< B) + S[2i], then go to HB.
REQ-020 Encrypt HB SHALL compute B = ((B ^ A) <<< A) + S[2i+1], using the new A.
- If i < R: i = i+1, go to HA.
- If i = R: go to DONE.
REQ-021 Decrypt HB SHALL compute B = ((B - S[2i+1]) >>> A) ^ A, then go to HA.
REQ-022 Decrypt HA SHALL compute A = ((A - S[2i]) >>> B) ^ B, using the new B.
- If i > 1: i = i-1, go to HB.
- If i = 1: go to POST.
REQ-023 Decrypt POST SHALL compute B = B - S[1] and A = A - S[0], then go to DONE.
REQ-024 Arithmetic and rotation rules:
- All add/subtract SHALL be modulo 2^W.
- Rotate amount SHALL be the low log2(W) bits of the named word.
- Each rotation SHALL complete in one cycle (full barrel rotator).
REQ-025 Latency: for acceptance at edge k, out_valid SHALL rise after edge k+2R+1 for both modes.
REQ-026 DONE handshake:
- out_valid = 1, and out_a/out_b SHALL hold the final A/B stable.
- The core SHALL stay in DONE while out_ready = 0.
- On an edge with out_ready = 1: go to IDLE, and out_valid = 0 after that edge.
REQ-027 in_valid asserted outside IDLE SHALL have no effect; the input is not captured until in_ready = 1.
REQ-028 A new block SHALL NOT be accepted in the same cycle the DONE->IDLE handshake completes; in_ready rises the cycle after.

Reset
REQ-029 While reset = 1, the core SHALL immediately enter the following state:
- state = IDLE, in_ready = 1, out_valid = 0;
- out_a = 0, out_b = 0;
- all S[] = 0, internal A/B/i cleared.
REQ-030 Reset asserted mid-operation SHALL abort the block with no output produced; after release, the core SHALL accept a new block normally.

Verification
REQ-031 W=8, R=1, all S = 0, encrypt A=01, B=00 -> out_a=01, out_b=02 after 3 cycles.
REQ-032 W=8, R=1, S0=01, S1=02, S2=S3=00, encrypt A=00, B=00 -> out_a=0C, out_b=E0; decrypt of (0C, E0) -> (00, 00).
REQ-033 Defaults W=8, R=6, random key table, 200 random blocks: encrypt then decrypt -> original A/B every time; latency exactly 13 cycles each.
REQ-034 Backpressure: out_ready = 0 for 10 cycles in DONE -> out_a/out_b stable, in_ready = 0, key_we writes ignored (S unchanged on readback by re-encrypting a known vector).
REQ-035 Reset pulse at cycle 5 of a block -> out_valid never asserts for it, in_ready = 1 and S all zero; REQ-031 vector then passes.
REQ-036 key_addr = T with key_we -> no S entry changes; REQ-032 vector still gives (0C, E0).

Source files
------------

// File: rtl/rc5_core.sv
// RC5 block cipher core: one half-round per clock, encrypt and decrypt.
// The key table S[0..T-1] is loaded word by word through key_we while the
// core is idle. A block is taken in through a valid/ready handshake, runs for
// 2R+1 cycles, and is held in DONE until the consumer takes it.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. in_ready and out_valid come straight from the
// state register. The result words stay stable while out_valid waits for
// out_ready.
module rc5_core #(
    parameter int W = 8,
    parameter int R = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         key_we,
    input  logic [5:0]   key_addr,
    input  logic [W-1:0] key_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [2:0]   dbg_state
);

    localparam int T  = 2 * R + 2;
    localparam int IW = $clog2(T);
    localparam int LW = $clog2(W);

    localparam logic [6:0]    T_LIM  = 7'(T);
    localparam logic [IW-1:0] I_LAST = IW'(R);
    localparam logic [IW-1:0] I_ONE  = IW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HA   = 3'd2,
        HB   = 3'd3,
        POST = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t        state_q, state_n;
    logic [W-1:0]  a_q, a_n;
    logic [W-1:0]  b_q, b_n;
    logic [IW-1:0] i_q, i_n;
    logic          mode_q, mode_n;

    logic [W-1:0]  s_tab [T];

    // Key-table addresses for the current round: 2i and 2i+1.
    // 2i never exceeds T-1, so the top bit of i is always zero here.
    logic [IW-1:0] ka, kb;
    logic [W-1:0]  s_ka, s_kb;
    logic [IW-1:0] wr_ix;
    logic          key_hit;

    // Half-round results for both directions.
    logic [W-1:0]  enc_a, enc_b, dec_a, dec_b;

    // Left rotate by the low log2(W) bits of the amount word.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        return (x << n) | (x >> (W - int'(n)));
    endfunction

    // Right rotate by the low log2(W) bits of the amount word.
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
        return (x >> n) | (x << (W - int'(n)));
    endfunction

    assign ka      = {i_q[IW-2:0], 1'b0};
    assign kb      = {i_q[IW-2:0], 1'b1};
    assign s_ka    = s_tab[ka];
    assign s_kb    = s_tab[kb];
    assign wr_ix   = IW'(key_addr);
    assign key_hit = key_we && (state_q == IDLE) && ({1'b0, key_addr} < T_LIM);

    // Encrypt HB and decrypt HA both use the word that was updated one cycle
    // earlier, and that word is already in its register.
    assign enc_a = rotl(a_q ^ b_q, b_q[LW-1:0]) + s_ka;
    assign enc_b = rotl(b_q ^ a_q, a_q[LW-1:0]) + s_kb;
    assign dec_b = rotr(b_q - s_kb, a_q[LW-1:0]) ^ a_q;
    assign dec_a = rotr(a_q - s_ka, b_q[LW-1:0]) ^ b_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Datapath registers: working words, round index and direction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            i_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            a_q    <= a_n;
            b_q    <= b_n;
            i_q    <= i_n;
            mode_q <= mode_n;
        end
    end

    // Key table. Writes are accepted only while idle and only for in-range
    // addresses, so a running block always sees a constant table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < T; j++) begin
                s_tab[j] <= '0;
            end
        end else if (key_hit) begin
            s_tab[wr_ix] <= key_data;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        i_n     = i_q;
        mode_n  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_n    = in_a;
                    b_n    = in_b;
                    mode_n = in_mode;
                    if (in_mode) begin
                        i_n     = I_LAST;
                        state_n = HB;
                    end else begin
                        i_n     = I_ONE;
                        state_n = PRE;
                    end
                end
            end
            PRE: begin
                a_n     = a_q + s_tab[0];
                b_n     = b_q + s_tab[1];
                state_n = HA;
            end
            HA: begin
                if (!mode_q) begin
                    a_n     = enc_a;
                    state_n = HB;
                end else begin
                    a_n = dec_a;
                    if (i_q > I_ONE) begin
                        i_n     = i_q - I_ONE;
                        state_n = HB;
                    end else begin
                        state_n = POST;
                    end
                end
            end
            HB: begin
                if (!mode_q) begin
                    b_n = enc_b;
                    if (i_q < I_LAST) begin
                        i_n     = i_q + I_ONE;
                        state_n = HA;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    b_n     = dec_b;
                    state_n = HA;
                end
            end
            POST: begin
                b_n     = b_q - s_tab[1];
                a_n     = a_q - s_tab[0];
                state_n = DONE;
            end
            DONE: begin
                // Returning to IDLE here means in_ready rises only after the
                // handshake edge, so no block is accepted on that same edge.
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
